// File: rtl/pipe_share_arb.sv
// pipe_share_arb: round-robin arbiter and in-flight tracker in front of a
// shared, fixed-latency, reset-less pipelined datapath.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   req_valid/data   per-requester operand requests (requester i at [i*WIDTH +: WIDTH])
//   req_ready        one-hot grant (combinational)
//   pipe_in_valid    operand issued to the shared unit this cycle (combinational)
//   pipe_in_data     winner's operand, 0 when idle (combinational)
//   pipe_out_data    shared unit result, exactly LATENCY cycles after issue
//   rsp_valid        one-hot result strobe from the tag delay line
//   rsp_data         pass-through of pipe_out_data, qualified by rsp_valid
//   busy             at least one operation in flight
module pipe_share_arb #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned LATENCY      = 4,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     pipe_in_valid,
    output logic [WIDTH-1:0]         pipe_in_data,
    input  logic [WIDTH-1:0]         pipe_out_data,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_INFLIGHT);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    logic [PW-1:0]    ptr;
    logic [LATENCY-1:0] tag_vld;
    logic [N_REQ-1:0] tag_oh [LATENCY];
    logic [CW-1:0]    inflight [N_REQ];

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant_oh;
    logic             grant;
    logic [PW-1:0]    winner;
    logic [SW-1:0]    scan;

    // Response side comes straight from the last tag stage.
    assign rsp_valid = tag_vld[LATENCY-1] ? tag_oh[LATENCY-1] : '0;
    assign rsp_data  = pipe_out_data;
    assign busy      = |tag_vld;

    // A response retiring this cycle frees its slot for a same-cycle grant,
    // so a requester at the limit stays eligible while its results drain.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = !rst && req_valid[i] &&
                          ((inflight[i] < MAX_CNT) || rsp_valid[i]);
        end
    end

    // First eligible index at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        scan   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr} + SW'(k);
            if (scan >= SW'(N_REQ)) begin
                scan = scan - SW'(N_REQ);
            end
            if (!grant && eligible[scan[PW-1:0]]) begin
                grant  = 1'b1;
                winner = scan[PW-1:0];
            end
        end
    end

    assign grant_oh      = grant ? (N_REQ'(1) << winner) : '0;
    assign req_ready     = grant_oh;
    assign pipe_in_valid = grant;

    // Operand mux; zero when nobody is granted.
    always_comb begin
        pipe_in_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                pipe_in_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Tag delay line matching the shared unit latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                tag_oh[s] <= '0;
            end
        end else begin
            tag_vld[0] <= grant;
            tag_oh[0]  <= grant_oh;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_oh[s]  <= tag_oh[s-1];
            end
        end
    end

    // Per-requester outstanding-operation counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                inflight[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant_oh[i] && !rsp_valid[i]) begin
                    inflight[i] <= inflight[i] + CW'(1);
                end else if (!grant_oh[i] && rsp_valid[i]) begin
                    inflight[i] <= inflight[i] - CW'(1);
                end
            end
        end
    end

    // Priority pointer moves just past the winner; holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (winner == LAST_IDX) ? '0 : winner + PW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_share_arb.sv
// tb_pipe_share_arb: bench for pipe_share_arb. Two instances share clk/rst:
// u_dut (MAX_INFLIGHT=2) and u_dut4 (MAX_INFLIGHT=LATENCY=4). Each has its own
// reset-less shared-unit model computing unit_f() with LATENCY cycles of delay.
module tb_pipe_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned L  = 4;
    localparam int unsigned MI = 2;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] res;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_valid4;
    logic [N*W-1:0] req_data, req_data4;
    logic [N-1:0]   req_ready, req_ready4;
    logic           pipe_in_valid, pipe_in_valid4;
    logic [W-1:0]   pipe_in_data, pipe_in_data4;
    logic [W-1:0]   pipe_out_data, pipe_out_data4;
    logic [N-1:0]   rsp_valid, rsp_valid4;
    logic [W-1:0]   rsp_data, rsp_data4;
    logic           busy, busy4;

    logic [W-1:0]   pl  [L];
    logic [W-1:0]   pl4 [L];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] unit_f(input logic [31:0] x);
        return ({x[15:0], x[31:16]} ^ 32'h5A5A_1234) + 32'd7;
    endfunction

    // Reset-less shared units.
    always @(posedge clk) begin
        pl[0]  <= unit_f(pipe_in_data);
        pl4[0] <= unit_f(pipe_in_data4);
        for (int s = 1; s < int'(L); s++) begin
            pl[s]  <= pl[s-1];
            pl4[s] <= pl4[s-1];
        end
    end
    assign pipe_out_data  = pl[L-1];
    assign pipe_out_data4 = pl4[L-1];

    pipe_share_arb #(.N_REQ(N), .WIDTH(W), .LATENCY(L), .MAX_INFLIGHT(MI)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data),
        .pipe_out_data(pipe_out_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    pipe_share_arb #(.N_REQ(N), .WIDTH(W), .LATENCY(L), .MAX_INFLIGHT(L)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_data(req_data4),
        .req_ready(req_ready4), .pipe_in_valid(pipe_in_valid4), .pipe_in_data(pipe_in_data4),
        .pipe_out_data(pipe_out_data4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .busy(busy4)
    );

    task automatic apply_reset();
        rst = 1'b1;
        req_valid  = '0;
        req_valid4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_valid4 = 4'hF;
        req_data   = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        req_data4  = req_data;
        @(negedge clk);
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (pipe_in_valid !== 1'b0) begin bad++; $display("FAIL reset_pvalid got=%b exp=0", pipe_in_valid); end
        total++; if (pipe_in_data !== 32'h0) begin bad++; $display("FAIL reset_pdata got=%h exp=0", pipe_in_data); end
        total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp got=%b exp=0000", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (req_ready4 !== 4'b0) begin bad++; $display("FAIL reset_ready4 got=%b exp=0000", req_ready4); end
        req_valid  = '0;
        req_valid4 = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]  er, ev;
        logic [31:0] ed;
        logic        eb;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            req_data  = '0;
            req_data[1*W +: W] = 32'h11;
            er = (c == 0) ? 4'b0010 : 4'b0000;
            ed = (c == 0) ? 32'h11 : 32'h0;
            ev = (c == 4) ? 4'b0010 : 4'b0000;
            eb = (c >= 1) && (c <= 4);
            @(negedge clk);
            total++; if (req_ready !== er) begin bad++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            total++; if (pipe_in_data !== ed) begin bad++; $display("FAIL single_pdata c=%0d got=%h exp=%h", c, pipe_in_data, ed); end
            total++; if (rsp_valid !== ev) begin bad++; $display("FAIL single_rsp c=%0d got=%b exp=%b", c, rsp_valid, ev); end
            total++; if (busy !== eb) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, eb); end
            if (ev != 0) begin
                total++; if (rsp_data !== unit_f(32'h11)) begin bad++; $display("FAIL single_rdata got=%h exp=%h", rsp_data, unit_f(32'h11)); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness();
        int          round [4];
        int          g, t;
        logic [3:0]  er, ev;
        logic [31:0] ed, erd;
        for (int i = 0; i < 4; i++) round[i] = 0;
        for (int c = 0; c < 13; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) req_data[i*W +: W] = 32'h100 * (i + 1) + 32'(round[i]);
            g  = c % 4;
            er = (c < 8) ? 4'(1 << g) : 4'b0;
            ed = (c < 8) ? 32'h100 * (g + 1) + 32'(c / 4) : 32'h0;
            t  = (c - 4) % 4;
            ev = (c >= 4 && c < 12) ? 4'(1 << t) : 4'b0;
            erd = unit_f(32'h100 * (t + 1) + 32'((c - 4) / 4));
            @(negedge clk);
            total++; if (req_ready !== er) begin bad++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            total++; if (pipe_in_data !== ed) begin bad++; $display("FAIL fair_pdata c=%0d got=%h exp=%h", c, pipe_in_data, ed); end
            total++; if (rsp_valid !== ev) begin bad++; $display("FAIL fair_rsp c=%0d got=%b exp=%b", c, rsp_valid, ev); end
            if (ev != 0) begin
                total++; if (rsp_data !== erd) begin bad++; $display("FAIL fair_rdata c=%0d got=%h exp=%h", c, rsp_data, erd); end
            end
            if (c < 8) round[g]++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_inflight_limit();
        int          gcnt, rcnt;
        logic        eg, er_v;
        gcnt = 0;
        rcnt = 0;
        for (int c = 0; c < 17; c++) begin
            req_valid = (c < 12) ? 4'b1000 : 4'b0000;
            req_data  = '0;
            req_data[3*W +: W] = 32'hA0 + 32'(gcnt);
            eg   = (c < 12) && ((c % 4) < 2);
            er_v = (c >= 4) && (c < 16) && ((c % 4) < 2);
            @(negedge clk);
            total++; if (req_ready !== (eg ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL limit_ready c=%0d got=%b exp_grant=%b", c, req_ready, eg); end
            total++; if (rsp_valid !== (er_v ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL limit_rsp c=%0d got=%b exp_rsp=%b", c, rsp_valid, er_v); end
            if (er_v) begin
                total++; if (rsp_data !== unit_f(32'hA0 + 32'(rcnt))) begin bad++; $display("FAIL limit_rdata c=%0d got=%h exp=%h", c, rsp_data, unit_f(32'hA0 + 32'(rcnt))); end
                rcnt++;
            end
            if (eg) gcnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] rv, er, ev;
        for (int c = 0; c < 9; c++) begin
            rv = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0110 : (c == 2) ? 4'b0010 : 4'b0000;
            er = (c == 0) ? 4'b0001 : (c == 1 || c == 2) ? 4'b0010 : 4'b0000;
            ev = (c == 4) ? 4'b0001 : (c == 5 || c == 6) ? 4'b0010 : 4'b0000;
            req_valid = rv;
            for (int i = 0; i < 4; i++) req_data[i*W +: W] = 32'h300 + 32'(c);
            @(negedge clk);
            total++; if (req_ready !== er) begin bad++; $display("FAIL withdraw_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            total++; if (rsp_valid !== ev) begin bad++; $display("FAIL withdraw_rsp c=%0d got=%b exp=%b", c, rsp_valid, ev); end
            if (ev != 0) begin
                total++; if (rsp_data !== unit_f(32'h300 + 32'(c - 4))) begin bad++; $display("FAIL withdraw_rdata c=%0d got=%h exp=%h", c, rsp_data, unit_f(32'h300 + 32'(c - 4))); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] er, ev;
        for (int i = 0; i < 4; i++) req_data[i*W +: W] = 32'h400 + 32'(i);
        for (int c = 0; c < 3; c++) begin
            req_valid = (c == 0) ? 4'b0111 : (c == 1) ? 4'b0110 : 4'b0100;
            er = 4'(1 << c);
            @(negedge clk);
            total++; if (req_ready !== er) begin bad++; $display("FAIL rmid_pre_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        #2 rst = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0000", req_ready); end
        total++; if (pipe_in_valid !== 1'b0) begin bad++; $display("FAIL rmid_pvalid got=%b exp=0", pipe_in_valid); end
        total++; if (pipe_in_data !== 32'h0) begin bad++; $display("FAIL rmid_pdata got=%h exp=0", pipe_in_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < int'(L) + 2; c++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL rmid_ghost c=%0d got=%b exp=0000", c, rsp_valid); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle_busy c=%0d got=%b exp=0", c, busy); end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 4) ? 4'hF : 4'h0;
            er = (c < 4) ? 4'(1 << c) : 4'b0;
            ev = (c >= 4 && c < 8) ? 4'(1 << (c - 4)) : 4'b0;
            @(negedge clk);
            total++; if (req_ready !== er) begin bad++; $display("FAIL rmid_resume_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rmid_resume_rsp c=%0d got=%b exp=%b", c, rsp_valid, ev); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        logic [3:0] ev;
        req_data4 = '0;
        for (int c = 0; c < 21; c++) begin
            req_valid4 = (c < 16) ? 4'b0001 : 4'b0000;
            req_data4[0 +: W] = 32'h500 + 32'(c);
            ev = (c >= 4 && c < 20) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            total++; if (req_ready4 !== ((c < 16) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL sat_ready c=%0d got=%b", c, req_ready4); end
            total++; if (rsp_valid4 !== ev) begin bad++; $display("FAIL sat_rsp c=%0d got=%b exp=%b", c, rsp_valid4, ev); end
            total++; if (busy4 !== (c >= 1 && c < 20)) begin bad++; $display("FAIL sat_busy c=%0d got=%b", c, busy4); end
            if (ev != 0) begin
                total++; if (rsp_data4 !== unit_f(32'h500 + 32'(c - 4))) begin bad++; $display("FAIL sat_rdata c=%0d got=%h exp=%h", c, rsp_data4, unit_f(32'h500 + 32'(c - 4))); end
            end
            @(posedge clk); #1;
        end
    endtask

    // Randomized traffic against a queue-based model of outstanding operations.
    task automatic test_random();
        logic [3:0]  rv, er, ev;
        logic [31:0] rd [4];
        logic [31:0] ed, erd;
        logic        eb;
        int          m_ptr, w, j;
        int          m_inf [4];
        rsp_t        m_q [$];
        rv    = '0;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            m_inf[i] = 0;
            rd[i]    = '0;
        end
        for (int c = 0; c < 320; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (c >= 300) begin
                    rv[i] = 1'b0;
                end else if (!rv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rv[i] = 1'b1;
                        rd[i] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            req_valid = rv;
            for (int i = 0; i < 4; i++) req_data[i*W +: W] = rd[i];
            ev  = '0;
            erd = '0;
            if (m_q.size() > 0 && m_q[0].due == c) begin
                ev[m_q[0].idx] = 1'b1;
                erd = m_q[0].res;
            end
            eb = (m_q.size() > 0);
            w  = -1;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (w < 0 && rv[j] && (m_inf[j] - int'(ev[j])) < int'(MI)) w = j;
            end
            er = (w >= 0) ? 4'(1 << w) : 4'b0;
            ed = (w >= 0) ? rd[w] : 32'h0;
            @(negedge clk);
            total++; if (req_ready !== er) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            total++; if (pipe_in_valid !== (w >= 0)) begin bad++; $display("FAIL rand_pvalid c=%0d got=%b", c, pipe_in_valid); end
            total++; if (pipe_in_data !== ed) begin bad++; $display("FAIL rand_pdata c=%0d got=%h exp=%h", c, pipe_in_data, ed); end
            total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rand_rsp c=%0d got=%b exp=%b", c, rsp_valid, ev); end
            total++; if (busy !== eb) begin bad++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, eb); end
            if (ev != 0) begin
                total++; if (rsp_data !== erd) begin bad++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, rsp_data, erd); end
                m_inf[m_q[0].idx]--;
                void'(m_q.pop_front());
            end
            if (w >= 0) begin
                m_inf[w]++;
                m_q.push_back('{due: c + int'(L), idx: w, res: unit_f(rd[w])});
                m_ptr = (w + 1) % 4;
                rv[w] = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        req_data  = '0;
        req_data4 = '0;
        test_reset();
        test_single();
        apply_reset();
        test_fairness();
        apply_reset();
        test_inflight_limit();
        apply_reset();
        test_withdraw();
        apply_reset();
        test_reset_mid();
        apply_reset();
        test_saturate();
        apply_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
